// File: rtl/calc_resp_collector_if.sv
// calc_resp_collector_if: DUT response ports plus the serialised collector stream; CALC_RESP_STATS_EN adds handshake counters
interface calc_resp_collector_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0] out_resp1, out_resp2, out_resp3, out_resp4;
  logic [1:0] out_tag1, out_tag2, out_tag3, out_tag4;
  logic [DATA_WIDTH-1:0] out_data1, out_data2, out_data3, out_data4;
  logic col_valid;
  logic col_ready;
  logic [1:0] col_port;
  logic [1:0] col_resp;
  logic [1:0] col_tag;
  logic [DATA_WIDTH-1:0] col_data;
  logic [3:0] ovf_flag;
`ifdef CALC_RESP_STATS_EN
  logic [15:0] resp_count;
  logic [15:0] err_count;
  modport master (
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_tag1, out_tag2, out_tag3, out_tag4,
    output out_data1, out_data2, out_data3, out_data4,
    output col_ready,
    input col_valid, col_port, col_resp, col_tag, col_data, ovf_flag,
    input resp_count, err_count
  );
  modport slave (
    input out_resp1, out_resp2, out_resp3, out_resp4,
    input out_tag1, out_tag2, out_tag3, out_tag4,
    input out_data1, out_data2, out_data3, out_data4,
    input col_ready,
    output col_valid, col_port, col_resp, col_tag, col_data, ovf_flag,
    output resp_count, err_count
  );
`else
  modport master (
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_tag1, out_tag2, out_tag3, out_tag4,
    output out_data1, out_data2, out_data3, out_data4,
    output col_ready,
    input col_valid, col_port, col_resp, col_tag, col_data, ovf_flag
  );
  modport slave (
    input out_resp1, out_resp2, out_resp3, out_resp4,
    input out_tag1, out_tag2, out_tag3, out_tag4,
    input out_data1, out_data2, out_data3, out_data4,
    input col_ready,
    output col_valid, col_port, col_resp, col_tag, col_data, ovf_flag
  );
`endif
endinterface

// File: rtl/calc_resp_collector.sv
// calc_resp_collector: buffers four DUT response ports in per-port FIFOs and serialises them round-robin onto one valid/ready stream; CALC_RESP_STATS_EN adds resp_count/err_count
module calc_resp_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic PClk,
  input logic Rst,
  calc_resp_collector_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 4;
  logic [1:0] in_resp [4];
  logic [1:0] in_tag [4];
  logic [DATA_WIDTH-1:0] in_data [4];
  logic [EW-1:0] head [4];
  logic [3:0] nonempty, pop, want, push_ok;
  logic [1:0] last_grant, win;
  logic load;
  assign in_resp = '{bus.out_resp1, bus.out_resp2, bus.out_resp3, bus.out_resp4};
  assign in_tag = '{bus.out_tag1, bus.out_tag2, bus.out_tag3, bus.out_tag4};
  assign in_data = '{bus.out_data1, bus.out_data2, bus.out_data3, bus.out_data4};
  assign load = (!bus.col_valid || bus.col_ready) && |nonempty;
  // round-robin pick: the first non-empty port after last_grant wins (smallest offset has priority)
  always_comb begin
    win = last_grant;
    for (int k = 4; k >= 1; k--) win = nonempty[last_grant + 2'(k)] ? last_grant + 2'(k) : win;
  end
  for (genvar i = 0; i < 4; i++) begin : g_fifo
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt;
    assign want[i] = in_resp[i] != 2'd0;
    assign pop[i] = load && win == 2'(i);
    assign push_ok[i] = want[i] && (cnt < (AW+1)'(FIFO_DEPTH) || pop[i]);
    assign nonempty[i] = cnt != '0;
    assign head[i] = mem[rd_ptr];
    // per-port FIFO; a pop frees a slot for a push on the same edge even when full
    always_ff @(posedge PClk) begin
      if (Rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
      end else begin
        if (push_ok[i]) begin
          mem[wr_ptr] <= {in_resp[i], in_tag[i], in_data[i]};
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop[i]) rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + (AW+1)'(push_ok[i]) - (AW+1)'(pop[i]);
      end
    end
  end
  // output register: load the winner when free or being accepted, drop valid after the last handshake
  always_ff @(posedge PClk) begin
    if (Rst) begin
      bus.col_valid <= 1'b0;
      bus.col_port <= '0;
      bus.col_resp <= '0;
      bus.col_tag <= '0;
      bus.col_data <= '0;
      last_grant <= 2'd3;
    end else if (load) begin
      bus.col_valid <= 1'b1;
      bus.col_port <= win;
      {bus.col_resp, bus.col_tag, bus.col_data} <= head[win];
      last_grant <= win;
    end else if (bus.col_ready) bus.col_valid <= 1'b0;
  end
  // sticky per-port overflow: a response arrived that could not be buffered
  always_ff @(posedge PClk) bus.ovf_flag <= Rst ? 4'd0 : bus.ovf_flag | (want & ~push_ok);
`ifdef CALC_RESP_STATS_EN
  logic hs;
  assign hs = bus.col_valid && bus.col_ready;
  // saturating counters of accepted entries and of accepted error entries
  always_ff @(posedge PClk) begin
    if (Rst) begin
      bus.resp_count <= '0;
      bus.err_count <= '0;
    end else if (hs) begin
      if (bus.resp_count != 16'hFFFF) bus.resp_count <= bus.resp_count + 16'd1;
      if (bus.col_resp == 2'd2 && bus.err_count != 16'hFFFF) bus.err_count <= bus.err_count + 16'd1;
    end
  end
`endif
endmodule
